// File: rtl/seq_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_multi
// Brief    : Streaming generator for Fibonacci, Padovan, Tribonacci and Pell
//            sequences, with wrap or saturate handling of term overflow.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen_multi #(
    parameter int WIDTH    = 32,
    parameter int COUNT_W  = 16,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   seed0,
    input  logic [WIDTH-1:0]   seed1,
    input  logic [WIDTH-1:0]   seed2,
    input  logic [COUNT_W-1:0] len,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [COUNT_W-1:0] out_index,
    output logic               out_last,
    output logic               out_ovf,
    output logic               ovf_seen,
    output logic               busy,
    output logic               done
);

    localparam logic [COUNT_W-1:0] c_cnt_one = {{(COUNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_done_nxt;
    logic   r_done;

    logic [WIDTH-1:0]   r_a, r_b, r_c;
    logic               r_ovf_a, r_ovf_b, r_ovf_c;
    logic [1:0]         r_mode;
    logic [COUNT_W-1:0] r_len;
    logic [COUNT_W-1:0] r_index;
    logic               r_ovf_seen;

    logic               w_run;
    logic               w_xfer;
    logic               w_last;
    logic [WIDTH+1:0]   w_sum;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_term;

    assign w_run  = (r_state == RUN);
    assign w_xfer = w_run && out_ready;
    assign w_last = w_run && (r_len != '0) && (r_index == (r_len - c_cnt_one));

    // Two guard bits cover the largest sum (3x the maximum term)
    always_comb begin
        w_sum = '0;
        case (r_mode)
            2'd0:    w_sum = {2'b00, r_b} + {2'b00, r_c};
            2'd1:    w_sum = {2'b00, r_a} + {2'b00, r_b};
            2'd2:    w_sum = {2'b00, r_a} + {2'b00, r_b} + {2'b00, r_c};
            default: w_sum = {1'b0, r_c, 1'b0} + {2'b00, r_b};
        endcase
    end

    assign w_ovf = |w_sum[WIDTH+1:WIDTH];

    generate
        if (SATURATE != 0) begin : g_sat
            assign w_term = w_ovf ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        end else begin : g_wrap
            assign w_term = w_sum[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Abort takes priority over a coinciding final transfer, so no done pulse
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = RUN;
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_xfer && w_last) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_ovf_a    <= 1'b0;
            r_ovf_b    <= 1'b0;
            r_ovf_c    <= 1'b0;
            r_mode     <= 2'd0;
            r_len      <= '0;
            r_index    <= '0;
            r_ovf_seen <= 1'b0;
        end else if (!w_run && start) begin
            r_a        <= seed0;
            r_b        <= seed1;
            r_c        <= seed2;
            r_ovf_a    <= 1'b0;
            r_ovf_b    <= 1'b0;
            r_ovf_c    <= 1'b0;
            r_mode     <= mode;
            r_len      <= len;
            r_index    <= '0;
            r_ovf_seen <= 1'b0;
        end else if (w_xfer) begin
            r_a        <= r_b;
            r_b        <= r_c;
            r_c        <= w_term;
            r_ovf_a    <= r_ovf_b;
            r_ovf_b    <= r_ovf_c;
            r_ovf_c    <= w_ovf;
            r_index    <= r_index + c_cnt_one;
            if (r_ovf_a) r_ovf_seen <= 1'b1;
        end
    end

    assign out_valid = w_run;
    assign busy      = w_run;
    assign out_data  = r_a;
    assign out_index = r_index;
    assign out_last  = w_last;
    assign out_ovf   = r_ovf_a;
    assign ovf_seen  = r_ovf_seen;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_gen_multi
// Brief    : Directed table-driven bench for seq_gen_multi (32-bit wrap plus
//            8-bit wrap and 8-bit saturate instances sharing control inputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen_multi;

    logic        clk = 1'b0;
    logic        rst, start, abort, out_ready;
    logic [1:0]  mode;
    logic [31:0] seed0, seed1, seed2;
    logic [15:0] len;

    logic        v32, last32, ovf32, seen32, busy32, done32;
    logic [31:0] d32;
    logic [15:0] i32;
    logic        vw, lastw, ovfw, seenw, busyw, donew;
    logic [7:0]  dw;
    logic [15:0] iw;
    logic        vs, lasts, ovfs, seens, busys, dones;
    logic [7:0]  ds;
    logic [15:0] is_;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_gen_multi #(.WIDTH(32), .COUNT_W(16), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .seed0(seed0), .seed1(seed1), .seed2(seed2), .len(len), .abort(abort),
        .out_valid(v32), .out_ready(out_ready), .out_data(d32), .out_index(i32),
        .out_last(last32), .out_ovf(ovf32), .ovf_seen(seen32), .busy(busy32), .done(done32));

    seq_gen_multi #(.WIDTH(8), .COUNT_W(16), .SATURATE(0)) dut_w8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .seed2(seed2[7:0]), .len(len), .abort(abort),
        .out_valid(vw), .out_ready(out_ready), .out_data(dw), .out_index(iw),
        .out_last(lastw), .out_ovf(ovfw), .ovf_seen(seenw), .busy(busyw), .done(donew));

    seq_gen_multi #(.WIDTH(8), .COUNT_W(16), .SATURATE(1)) dut_s8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .seed2(seed2[7:0]), .len(len), .abort(abort),
        .out_valid(vs), .out_ready(out_ready), .out_data(ds), .out_index(is_),
        .out_last(lasts), .out_ovf(ovfs), .ovf_seen(seens), .busy(busys), .done(dones));

    typedef struct packed {
        logic [1:0]        mode;
        logic [31:0]       s0;
        logic [31:0]       s1;
        logic [31:0]       s2;
        logic [15:0]       len;
        logic [9:0][31:0]  exp;
    } vec_t;

    vec_t vecs [4];
    int   fib_ref [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fill(input int n, input logic [1:0] m, input int a, input int b,
                        input int c, input int l, input int e [10]);
        vecs[n].mode = m;
        vecs[n].s0   = a;
        vecs[n].s1   = b;
        vecs[n].s2   = c;
        vecs[n].len  = 16'(l);
        for (int k = 0; k < 10; k++) vecs[n].exp[k] = e[k];
    endtask

    task automatic launch(input logic [1:0] m, input int a, input int b, input int c, input int l);
        @(negedge clk);
        start = 1'b1; mode = m; seed0 = a; seed1 = b; seed2 = c; len = 16'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        fill(0, 2'd0, 0, 1, 1, 10, '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34});
        fill(1, 2'd1, 1, 1, 1, 10, '{1, 1, 1, 2, 2, 3, 4, 5, 7, 9});
        fill(2, 2'd2, 0, 0, 1, 10, '{0, 0, 1, 1, 2, 4, 7, 13, 24, 44});
        fill(3, 2'd3, 0, 1, 2, 7,  '{0, 1, 2, 5, 12, 29, 70, 0, 0, 0});

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        mode = 2'd0; seed0 = 0; seed1 = 0; seed2 = 0; len = 0;
        repeat (2) @(negedge clk);
        check("reset_valid", v32, 0);
        check("reset_data", d32, 0);
        check("reset_index", i32, 0);
        check("reset_busy_done", {busy32, done32, seen32, last32, ovf32}, 0);
        rst = 1'b0;

        // Table-driven run per mode with out_ready held high
        foreach (vecs[n]) begin
            launch(vecs[n].mode, vecs[n].s0, vecs[n].s1, vecs[n].s2, int'(vecs[n].len));
            for (int k = 0; k < int'(vecs[n].len); k++) begin
                check($sformatf("tbl%0d_valid%0d", n, k), v32, 1);
                check($sformatf("tbl%0d_data%0d", n, k), d32, vecs[n].exp[k]);
                check($sformatf("tbl%0d_index%0d", n, k), i32, k);
                check($sformatf("tbl%0d_last%0d", n, k), last32, (k == int'(vecs[n].len) - 1));
                @(negedge clk);
            end
            check($sformatf("tbl%0d_end_valid", n), v32, 0);
            check($sformatf("tbl%0d_done", n), done32, 1);
            check($sformatf("tbl%0d_busy", n), busy32, 0);
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse", n), done32, 0);
        end

        // 8-bit overflow, wrap and saturate side by side
        launch(2'd0, 0, 1, 1, 16);
        repeat (13) @(negedge clk);
        check("w8_idx13_data", dw, 233);
        check("w8_idx13_ovf", ovfw, 0);
        check("s8_idx13_data", ds, 233);
        @(negedge clk);
        check("w8_idx14_data", dw, 121);
        check("w8_idx14_ovf", ovfw, 1);
        check("w8_seen_before", seenw, 0);
        check("s8_idx14_data", ds, 255);
        check("s8_idx14_ovf", ovfs, 1);
        @(negedge clk);
        check("w8_seen_after", seenw, 1);
        check("s8_seen_after", seens, 1);
        check("w8_idx15_data", dw, 98);
        check("w8_idx15_ovf", ovfw, 1);
        check("w8_idx15_last", lastw, 1);
        check("s8_idx15_data", ds, 255);
        check("s8_idx15_ovf", ovfs, 1);
        @(negedge clk);
        check("w8_done", donew, 1);
        launch(2'd0, 7, 0, 0, 1);
        check("s8_seen_cleared", seens, 0);
        check("len1_data", d32, 7);
        check("len1_last", last32, 1);
        @(negedge clk);
        check("len1_end_valid", v32, 0);
        check("len1_done", done32, 1);

        // Random backpressure: sequence must be intact, outputs held while stalled
        begin
            int k = 0;
            int cyc = 0;
            launch(2'd0, 0, 1, 1, 10);
            while (k < 10 && cyc < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                check($sformatf("bp_valid%0d", cyc), v32, 1);
                check($sformatf("bp_data%0d", cyc), d32, fib_ref[k]);
                check($sformatf("bp_index%0d", cyc), i32, k);
                @(negedge clk);
                if (out_ready) k++;
                cyc++;
            end
            check("bp_all_terms", k, 10);
            check("bp_done", done32, 1);
            out_ready = 1'b1;
        end

        // Abort at index 4
        launch(2'd0, 0, 1, 1, 10);
        repeat (4) @(negedge clk);
        check("abort_idx", i32, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", v32, 0);
        check("abort_no_done", done32, 0);
        @(negedge clk);
        check("abort_no_done_late", done32, 0);

        // Start during RUN is ignored
        launch(2'd0, 0, 1, 1, 10);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                start = 1'b1; mode = 2'd3; seed0 = 9; seed1 = 9; seed2 = 9;
            end else begin
                start = 1'b0;
            end
            check($sformatf("restart_data%0d", k), d32, fib_ref[k]);
            check($sformatf("restart_index%0d", k), i32, k);
            @(negedge clk);
        end
        start = 1'b0;
        check("restart_done", done32, 1);

        // Reset mid-run at index 6
        launch(2'd0, 0, 1, 1, 10);
        repeat (6) @(negedge clk);
        check("rst_idx", i32, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", v32, 0);
        check("rst_data", d32, 0);
        check("rst_index", i32, 0);
        check("rst_flags", {busy32, done32, seen32, last32, ovf32}, 0);

        // Unbounded run
        launch(2'd0, 0, 1, 1, 0);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("len0_last%0d", k), last32, 0);
            @(negedge clk);
        end
        check("len0_valid", v32, 1);
        check("len0_busy", busy32, 1);
        check("len0_index", i32, 20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("len0_abort", v32, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_gen_multi.md
Name: seq_gen_multi

Overview:
Parametrised recurrence-sequence generator. It emits a programmable-length stream of terms from one of four third-order-or-lower linear recurrences: Fibonacci, Padovan, Tribonacci or Pell. Seeds, mode and length are loaded per run. Output is a valid/ready stream with last, index and overflow tagging, and overflow handling is selectable as wrap or saturate. The block feeds downstream test-pattern and checksum logic in place of fixed single-sequence generators.

Parameters:
WIDTH, 32, term width in bits (min 4)
COUNT_W, 16, width of length and index fields
SATURATE, 0, 0 = wrap modulo 2^WIDTH on overflow; 1 = clamp to all-ones

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; accepted only in IDLE
mode  in  2  0 Fibonacci, 1 Padovan, 2 Tribonacci, 3 Pell; sampled on accepted start
seed0  in  WIDTH  term t0; sampled on accepted start
seed1  in  WIDTH  term t1; sampled on accepted start
seed2  in  WIDTH  term t2; sampled on accepted start
len  in  COUNT_W  number of terms to emit; 0 = unbounded
abort  in  1  terminate run; return to IDLE
out_valid  out  1  term available
out_ready  in  1  downstream accepts term
out_data  out  WIDTH  current term
out_index  out  COUNT_W  index of current term (0-based, wraps)
out_last  out  1  current term is term len-1 (never set when len=0)
out_ovf  out  1  current term was produced by an overflowing sum
ovf_seen  out  1  sticky: some emitted term had out_ovf; cleared on accepted start
busy  out  1  state is RUN
done  out  1  one-cycle pulse after final term transfer

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. All outputs 0, including out_data, out_index and ovf_seen. History registers and ovf bits cleared. rst overrides all other inputs, including mid-run.
- States: IDLE, RUN.
- IDLE to RUN on start. The next cycle has out_valid=1, out_data=seed0, out_index=0. start is ignored in RUN.
- History: registers a, b, c hold t_k, t_k+1, t_k+2, each with an ovf bit. out_data=a. Start loads a/b/c with seed0/seed1/seed2 and clears the ovf bits.
- Transfer occurs when out_valid and out_ready are both 1. On transfer: a<=b, b<=c, c<=f, out_index increments.
- Next-term function f, computed at WIDTH+2 bits:
  - Fibonacci: b+c
  - Padovan: a+b
  - Tribonacci: a+b+c
  - Pell: 2c+b
- Overflow: if any bit above WIDTH-1 is set, the term is wrapped (SATURATE=0) or clamped to 2^WIDTH-1 (SATURATE=1). The new c ovf bit is set; otherwise it is cleared. Ovf bits shift with a/b/c. out_ovf = ovf bit of a. ovf_seen sets on transfer of a term with out_ovf=1.
- Later terms use the wrapped or clamped stored values, not the true values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_index, out_last and out_ovf hold stable. No history update.
- Termination:
  - Transfer with out_last=1: next cycle IDLE, out_valid=0, done=1 for exactly one cycle.
  - len=0: runs indefinitely; out_index wraps from 2^COUNT_W-1 to 0.
  - len=1: a single term, seed0, with out_last=1.
  - len=2 and len=3 emit seeds only.
- Abort in RUN: next cycle IDLE, out_valid=0, no done pulse. If abort coincides with a transfer, the term counts as transferred but no further terms are emitted. Abort in IDLE has no effect. If start and abort are asserted together in IDLE, start is accepted.
- Latency: first term valid 1 cycle after start. One term per cycle with out_ready held at 1.
- busy=1 exactly while in RUN.

Test Plan:
- mode=0, seeds 0,1,1, len=10, ready=1: data 0,1,1,2,3,5,8,13,21,34 on consecutive cycles. out_last with 34 (index 9). done pulses the next cycle; busy drops.
- mode=1, seeds 1,1,1, len=10: 1,1,1,2,2,3,4,5,7,9. mode=2, seeds 0,0,1: 0,0,1,1,2,4,7,13,24,44. mode=3, seeds 0,1,2, len=7: 0,1,2,5,12,29,70.
- WIDTH=8, SATURATE=0, Fibonacci 0,1,1, len=16:
  - index 13 = 233 with out_ovf=0.
  - index 14 = 121 (377 mod 256) with out_ovf=1; ovf_seen set after its transfer.
  - index 15 = 98 (233+121 mod 256), out_ovf=1.
- Same with SATURATE=1: index 14 = 255 with ovf; index 15 = 255 with ovf; ovf_seen cleared by the next start.
- Random out_ready toggling on the Fibonacci len=10 run: data and index stable while stalled. Same 10-term sequence emitted, no drops or duplicates.
- Boundaries, each checked separately:
  - abort at index 4: out_valid=0 the next cycle, no done.
  - start during RUN: ignored.
  - rst at index 6: all outputs 0 the next cycle.
  - len=1: single seed0 with out_last.
  - len=0: still running after 20 terms.
